// File: rtl/glyph_pointer_gen_pkg.sv
// glyph_pointer_gen_pkg
//    Shared glyph codes, default glyph geometry and blink rate, and a
//    width helper used by the interface and the modules.
package glyph_pointer_gen_pkg;

   typedef logic [3:0] glyph_t;

   localparam glyph_t GLYPH_AM    = 4'd10;
   localparam glyph_t GLYPH_PM    = 4'd11;
   localparam glyph_t GLYPH_24H   = 4'd12;
   localparam glyph_t GLYPH_ROJO  = 4'd13;
   localparam glyph_t GLYPH_VERDE = 4'd14;
   localparam glyph_t GLYPH_BLANK = 4'd15;

   localparam int DEF_DIGIT_H      = 60;
   localparam int DEF_LABEL_H      = 20;
   localparam int DEF_BLINK_FRAMES = 30;

   // Index width for n items, never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/glyph_pointer_gen_if.sv
// glyph_pointer_gen_if
//    Bundles the slot-write port, blink controls, pixel request and
//    pointer result of glyph_pointer_gen.
//    master: drives wr_*, blink_mask, frame_tick, pix_*; receives out_*.
//    slave : the pointer generator.
interface glyph_pointer_gen_if #(
   parameter int SLOTS  = 6,
   parameter int ROW_W  = 6,
   parameter int ADDR_W = 10
);
   import glyph_pointer_gen_pkg::*;

   localparam int SLOT_W = idx_w(SLOTS);

   logic              wr_en;
   logic [SLOT_W-1:0] wr_slot;
   glyph_t            wr_value;
   logic [SLOTS-1:0]  blink_mask;
   logic              frame_tick;
   logic              pix_valid;
   logic [SLOT_W-1:0] pix_slot;
   logic [ROW_W-1:0]  pix_row;
   logic              out_valid;
   logic [ADDR_W-1:0] out_addr;
   logic              out_kind;
   logic              out_blank;

   modport master (
      output wr_en, wr_slot, wr_value, blink_mask, frame_tick,
      output pix_valid, pix_slot, pix_row,
      input  out_valid, out_addr, out_kind, out_blank
   );

   modport slave (
      input  wr_en, wr_slot, wr_value, blink_mask, frame_tick,
      input  pix_valid, pix_slot, pix_row,
      output out_valid, out_addr, out_kind, out_blank
   );

endinterface

// File: rtl/glyph_pointer_lut.sv
// glyph_pointer_lut
//    Combinational map from a glyph code to its ROM base pointer, ROM
//    select and glyph height.
//    i_value  : glyph code
//    o_ptr    : base address of the glyph in its ROM
//    o_kind   : 0 = digit ROM, 1 = label ROM
//    o_height : glyph height in rows
//    o_blank  : code draws nothing
module glyph_pointer_lut
   import glyph_pointer_gen_pkg::*;
#(
   parameter int DIGIT_H = DEF_DIGIT_H,
   parameter int LABEL_H = DEF_LABEL_H,
   parameter int ADDR_W  = 10
) (
   input  glyph_t            i_value,
   output logic [ADDR_W-1:0] o_ptr,
   output logic              o_kind,
   output logic [ADDR_W-1:0] o_height,
   output logic              o_blank
);

   always_comb begin
      o_ptr    = '0;
      o_kind   = 1'b1;
      o_height = ADDR_W'(LABEL_H);
      o_blank  = 1'b0;
      if (i_value <= 4'd9) begin
         o_ptr    = ADDR_W'(int'(i_value) * DIGIT_H);
         o_kind   = 1'b0;
         o_height = ADDR_W'(DIGIT_H);
      end else begin
         // The label ROM holds two glyphs: AM/24H/Rojo share the first,
         // PM/Verde share the second.
         case (i_value)
            GLYPH_PM, GLYPH_VERDE: o_ptr   = ADDR_W'(LABEL_H);
            GLYPH_BLANK:           o_blank = 1'b1;
            default:               o_ptr   = '0;
         endcase
      end
   end

endmodule

// File: rtl/glyph_pointer_gen.sv
// glyph_pointer_gen
//    Per-pixel glyph ROM pointer generator. Holds a bank of slot glyph
//    codes and a frame-based blink timer; each pixel request is turned
//    into a ROM address two cycles later with no stalls.
//    i_clk   : rising-edge clock
//    i_reset : synchronous active-high reset
//    bus     : slot writes, blink controls, pixel request, result
module glyph_pointer_gen
   import glyph_pointer_gen_pkg::*;
#(
   parameter int SLOTS        = 6,
   parameter int DIGIT_H      = DEF_DIGIT_H,
   parameter int LABEL_H      = DEF_LABEL_H,
   parameter int ROW_W        = 6,
   parameter int ADDR_W       = 10,
   parameter int BLINK_FRAMES = DEF_BLINK_FRAMES
) (
   input  logic              i_clk,
   input  logic              i_reset,
   glyph_pointer_gen_if.slave bus
);

   localparam int SLOT_W = idx_w(SLOTS);
   localparam int CNT_W  = idx_w(BLINK_FRAMES);
   localparam int CMP_W  = (ROW_W > ADDR_W) ? ROW_W : ADDR_W;

   if (10 * DIGIT_H > (1 << ADDR_W)) begin : g_addr_chk
      $error("glyph_pointer_gen: 10*DIGIT_H does not fit in ADDR_W bits");
   end

   glyph_t             r_slots [SLOTS];
   logic [CNT_W-1:0]   r_blink_cnt;
   logic               r_blink_phase;
   logic [1:0]         r_vld_pipe;
   glyph_t             r_s1_value;
   logic [ROW_W-1:0]   r_s1_row;
   logic               r_s1_blink;
   logic [ADDR_W-1:0]  r_out_addr;
   logic               r_out_kind;
   logic               r_out_blank;

   glyph_t             w_rd_value;
   logic               w_mask_bit;
   logic [ADDR_W-1:0]  w_ptr;
   logic [ADDR_W-1:0]  w_height;
   logic               w_kind;
   logic               w_lut_blank;
   logic               w_blank;
   logic [ADDR_W-1:0]  w_addr;

   // Stage 1 read. An out-of-range slot matches nothing and falls through
   // as the blank code, which also keeps the mask index in range.
   always_comb begin
      w_rd_value = GLYPH_BLANK;
      w_mask_bit = 1'b0;
      for (int i = 0; i < SLOTS; i++) begin
         if (bus.pix_slot == SLOT_W'(i)) begin
            w_rd_value = r_slots[i];
            w_mask_bit = bus.blink_mask[i];
         end
      end
   end

   glyph_pointer_lut #(
      .DIGIT_H (DIGIT_H),
      .LABEL_H (LABEL_H),
      .ADDR_W  (ADDR_W)
   ) u_lut (
      .i_value  (r_s1_value),
      .o_ptr    (w_ptr),
      .o_kind   (w_kind),
      .o_height (w_height),
      .o_blank  (w_lut_blank)
   );

   assign w_blank = w_lut_blank | r_s1_blink | (CMP_W'(r_s1_row) >= CMP_W'(w_height));
   assign w_addr  = w_ptr + ADDR_W'(r_s1_row);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int i = 0; i < SLOTS; i++) r_slots[i] <= GLYPH_BLANK;
         r_blink_cnt   <= '0;
         r_blink_phase <= 1'b0;
         r_vld_pipe    <= '0;
         r_s1_value    <= GLYPH_BLANK;
         r_s1_row      <= '0;
         r_s1_blink    <= 1'b0;
         r_out_addr    <= '0;
         r_out_kind    <= 1'b0;
         r_out_blank   <= 1'b1;
      end else begin
         for (int i = 0; i < SLOTS; i++) begin
            if (bus.wr_en && bus.wr_slot == SLOT_W'(i)) r_slots[i] <= bus.wr_value;
         end
         if (bus.frame_tick) begin
            if (r_blink_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
               r_blink_cnt   <= '0;
               r_blink_phase <= ~r_blink_phase;
            end else begin
               r_blink_cnt <= r_blink_cnt + 1'b1;
            end
         end
         r_vld_pipe <= {r_vld_pipe[0], bus.pix_valid};
         r_s1_value <= w_rd_value;
         r_s1_row   <= bus.pix_row;
         // Blink decision uses the phase/mask seen when the request entered.
         r_s1_blink <= r_blink_phase & w_mask_bit;
         if (r_vld_pipe[0]) begin
            r_out_addr  <= w_blank ? '0 : w_addr;
            r_out_kind  <= w_kind;
            r_out_blank <= w_blank;
         end
      end
   end

   assign bus.out_valid = r_vld_pipe[1];
   assign bus.out_addr  = r_out_addr;
   assign bus.out_kind  = r_out_kind;
   assign bus.out_blank = r_out_blank;

endmodule

// File: tb/tb_glyph_pointer_gen.sv
module tb_glyph_pointer_gen;
   localparam int SLOTS = 6, ROW_W = 6, ADDR_W = 10;
   localparam int DH = 60, LH = 20, BF = 30;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   glyph_pointer_gen_if #(.SLOTS(SLOTS), .ROW_W(ROW_W), .ADDR_W(ADDR_W)) bus ();

   glyph_pointer_gen #(
      .SLOTS(SLOTS), .DIGIT_H(DH), .LABEL_H(LH), .ROW_W(ROW_W),
      .ADDR_W(ADDR_W), .BLINK_FRAMES(BF)
   ) dut (
      .i_clk   (clk),
      .i_reset (reset),
      .bus     (bus)
   );

   int checks = 0;
   int failures = 0;

   // Reference model: glyph table per slot, blink frame count/phase, and
   // the result of each request queued until it reaches the output.
   typedef struct {bit v; int addr; bit kind; bit blank; bit kind_dc;} res_t;
   int   m_slot [SLOTS];
   int   m_cnt;
   bit   m_phase;
   res_t m_s1, m_out;

   function automatic res_t model_eval();
      res_t r;
      int v, h, p, s, row;
      bit k;
      r.v = bus.pix_valid; r.addr = 0; r.blank = 1; r.kind = 0; r.kind_dc = 1;
      s = int'(bus.pix_slot);
      row = int'(bus.pix_row);
      if (s >= SLOTS) return r;
      v = m_slot[s];
      if (v == 15) return r;
      if (v < 10) begin p = v * DH; h = DH; k = 0; end
      else begin p = (v == 11 || v == 14) ? LH : 0; h = LH; k = 1; end
      if (row >= h) return r;
      if (m_phase && bus.blink_mask[s]) return r;
      r.addr = p + row; r.blank = 0; r.kind = k; r.kind_dc = 0;
      return r;
   endfunction

   task automatic cycle();
      res_t req;
      bit rst, we, ft;
      int ws, wv;
      req = model_eval();
      rst = reset; we = bus.wr_en; ws = int'(bus.wr_slot); wv = int'(bus.wr_value);
      ft = bus.frame_tick;
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < SLOTS; i++) m_slot[i] = 15;
         m_cnt = 0; m_phase = 0; m_s1.v = 0;
         m_out.v = 0; m_out.addr = 0; m_out.kind = 0; m_out.blank = 1; m_out.kind_dc = 0;
      end else begin
         if (m_s1.v) m_out = m_s1; else m_out.v = 0;
         m_s1 = req;
         if (we && ws < SLOTS) m_slot[ws] = wv;
         if (ft) begin
            if (m_cnt == BF - 1) begin m_cnt = 0; m_phase = ~m_phase; end
            else m_cnt++;
         end
      end
      #1;
   endtask

   task automatic idle();
      bus.wr_en = 0; bus.wr_slot = '0; bus.wr_value = '0; bus.blink_mask = '0;
      bus.frame_tick = 0; bus.pix_valid = 0; bus.pix_slot = '0; bus.pix_row = '0;
   endtask

   task automatic wr(input int s, input int v);
      bus.wr_en = 1; bus.wr_slot = 3'(s); bus.wr_value = 4'(v);
      cycle();
      bus.wr_en = 0;
   endtask

   task automatic req(input int s, input int r);
      bus.pix_valid = 1; bus.pix_slot = 3'(s); bus.pix_row = 6'(r);
   endtask

   task automatic do_reset();
      reset = 1; cycle(); reset = 0;
   endtask

   task automatic test_reset();
      idle(); reset = 1; cycle(); cycle(); reset = 0;
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
      checks++; if (bus.out_addr !== 10'd0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", bus.out_addr); end
      checks++; if (bus.out_kind !== 1'b0) begin failures++; $display("FAIL reset_kind got=%b exp=0", bus.out_kind); end
      checks++; if (bus.out_blank !== 1'b1) begin failures++; $display("FAIL reset_blank got=%b exp=1", bus.out_blank); end
   endtask

   task automatic test_digit();
      wr(2, 7);
      req(2, 5); cycle(); bus.pix_valid = 0; cycle();
      checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL digit_valid got=%b exp=1", bus.out_valid); end
      checks++; if (bus.out_addr !== 10'd425) begin failures++; $display("FAIL digit_addr got=%0d exp=425", bus.out_addr); end
      checks++; if (bus.out_kind !== 1'b0) begin failures++; $display("FAIL digit_kind got=%b exp=0", bus.out_kind); end
      checks++; if (bus.out_blank !== 1'b0) begin failures++; $display("FAIL digit_blank got=%b exp=0", bus.out_blank); end
      cycle();
      checks++; if (bus.out_valid !== 1'b0 || bus.out_addr !== 10'd425) begin
         failures++; $display("FAIL digit_hold valid=%b addr=%0d exp valid=0 addr=425", bus.out_valid, bus.out_addr); end
   endtask

   task automatic test_label();
      wr(0, 11);
      req(0, 3); cycle(); req(0, 20); cycle();
      checks++; if (bus.out_addr !== 10'd23 || bus.out_kind !== 1'b1 || bus.out_blank !== 1'b0) begin
         failures++; $display("FAIL label_pm addr=%0d kind=%b blank=%b exp 23/1/0", bus.out_addr, bus.out_kind, bus.out_blank); end
      bus.pix_valid = 0; cycle();
      checks++; if (bus.out_valid !== 1'b1 || bus.out_addr !== 10'd0 || bus.out_blank !== 1'b1) begin
         failures++; $display("FAIL label_row_oob valid=%b addr=%0d blank=%b exp 1/0/1", bus.out_valid, bus.out_addr, bus.out_blank); end
   endtask

   task automatic test_same_cycle();
      wr(1, 9);
      bus.wr_en = 1; bus.wr_slot = 3'd1; bus.wr_value = 4'd3; req(1, 0);
      cycle();
      bus.wr_en = 0; cycle();
      checks++; if (bus.out_addr !== 10'd540) begin failures++; $display("FAIL rw_old got=%0d exp=540", bus.out_addr); end
      bus.pix_valid = 0; cycle();
      checks++; if (bus.out_addr !== 10'd180) begin failures++; $display("FAIL rw_new got=%0d exp=180", bus.out_addr); end
   endtask

   task automatic test_blink();
      do_reset();
      bus.blink_mask = 6'b000100;
      wr(2, 4); wr(3, 5);
      bus.frame_tick = 1; repeat (BF) cycle(); bus.frame_tick = 0;
      req(2, 7); cycle(); req(3, 7); cycle();
      checks++; if (bus.out_blank !== 1'b1 || bus.out_addr !== 10'd0) begin
         failures++; $display("FAIL blink_on blank=%b addr=%0d exp 1/0", bus.out_blank, bus.out_addr); end
      bus.pix_valid = 0; cycle();
      checks++; if (bus.out_blank !== 1'b0 || bus.out_addr !== 10'd307) begin
         failures++; $display("FAIL blink_other blank=%b addr=%0d exp 0/307", bus.out_blank, bus.out_addr); end
      bus.frame_tick = 1; repeat (BF) cycle(); bus.frame_tick = 0;
      req(2, 7); cycle(); bus.pix_valid = 0; cycle();
      checks++; if (bus.out_blank !== 1'b0 || bus.out_addr !== 10'd247) begin
         failures++; $display("FAIL blink_off blank=%b addr=%0d exp 0/247", bus.out_blank, bus.out_addr); end
      bus.blink_mask = '0;
   endtask

   task automatic test_oob();
      do_reset();
      wr(6, 3);
      for (int s = 0; s < 8; s++) begin
         req(s, 0); cycle(); bus.pix_valid = 0; cycle();
         checks++; if (bus.out_blank !== 1'b1 || bus.out_addr !== 10'd0) begin
            failures++; $display("FAIL oob_slot%0d blank=%b addr=%0d exp 1/0", s, bus.out_blank, bus.out_addr); end
      end
   endtask

   task automatic test_reset_midstream();
      wr(2, 1);
      req(2, 3); cycle(); cycle(); cycle();
      checks++; if (bus.out_valid !== 1'b1 || bus.out_addr !== 10'd63) begin
         failures++; $display("FAIL stream valid=%b addr=%0d exp 1/63", bus.out_valid, bus.out_addr); end
      reset = 1; bus.wr_en = 1; bus.wr_slot = 3'd2; bus.wr_value = 4'd5; cycle();
      reset = 0; bus.wr_en = 0;
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_v0 got=%b exp=0", bus.out_valid); end
      cycle();
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_v1 got=%b exp=0", bus.out_valid); end
      cycle();
      checks++; if (bus.out_valid !== 1'b1 || bus.out_blank !== 1'b1 || bus.out_addr !== 10'd0) begin
         failures++; $display("FAIL mid_rst_out valid=%b blank=%b addr=%0d exp 1/1/0", bus.out_valid, bus.out_blank, bus.out_addr); end
      bus.pix_valid = 0;
   endtask

   task automatic test_random();
      for (int n = 0; n < 800; n++) begin
         reset = ($urandom_range(0, 99) == 0);
         bus.wr_en = ($urandom_range(0, 3) == 0);
         bus.wr_slot = 3'($urandom_range(0, 7));
         bus.wr_value = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 15) == 0) bus.blink_mask = 6'($urandom);
         bus.frame_tick = ($urandom_range(0, 1) == 0);
         bus.pix_valid = ($urandom_range(0, 3) != 0);
         bus.pix_slot = 3'($urandom_range(0, 7));
         bus.pix_row = 6'($urandom_range(0, 63));
         cycle();
         checks++; if (bus.out_valid !== m_out.v) begin
            failures++; $display("FAIL rnd_valid n=%0d got=%b exp=%b", n, bus.out_valid, m_out.v); end
         checks++; if (bus.out_addr !== 10'(m_out.addr)) begin
            failures++; $display("FAIL rnd_addr n=%0d got=%0d exp=%0d", n, bus.out_addr, m_out.addr); end
         checks++; if (bus.out_blank !== m_out.blank) begin
            failures++; $display("FAIL rnd_blank n=%0d got=%b exp=%b", n, bus.out_blank, m_out.blank); end
         if (!m_out.kind_dc) begin
            checks++; if (bus.out_kind !== m_out.kind) begin
               failures++; $display("FAIL rnd_kind n=%0d got=%b exp=%b", n, bus.out_kind, m_out.kind); end
         end
      end
      reset = 0; idle();
   endtask

   initial begin
      test_reset();
      test_digit();
      test_label();
      test_same_cycle();
      test_blink();
      test_oob();
      test_reset_midstream();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/glyph_pointer_gen.md
GLYPH_POINTER_GEN -- requirements
Module: glyph_pointer_gen

Interface
REQ-001 Parameter SLOTS, default 6: number of on-screen character slots.
REQ-002 Parameter DIGIT_H, default 60: digit glyph height in rows, and the stride between digit glyphs in the digit ROM.
REQ-003 Parameter LABEL_H, default 20: label glyph height in rows, and the stride between label glyphs in the label ROM.
REQ-004 Parameter ROW_W, default 6: width of the glyph row index.
REQ-005 Parameter ADDR_W, default 10: ROM address width.
REQ-006 Parameter BLINK_FRAMES, default 30: frames per blink half-period.
REQ-007 Derived SLOT_W = max(1, clog2(SLOTS)).
REQ-008 The module SHALL have one clock; reset is synchronous and active-high.
REQ-009 clk  in  1  rising-edge system clock.
REQ-010 reset  in  1  synchronous active-high reset.
REQ-011 wr_en  in  1  slot write strobe.
REQ-012 wr_slot  in  SLOT_W  slot to write.
REQ-013 wr_value  in  4  glyph code: 0-9 digits, 10 AM, 11 PM, 12 24H, 13 Rojo, 14 Verde, 15 blank.
REQ-014 blink_mask  in  SLOTS  per-slot blink enable.
REQ-015 frame_tick  in  1  one-cycle pulse per video frame.
REQ-016 pix_valid  in  1  pixel request qualifier.
REQ-017 pix_slot  in  SLOT_W  slot under the beam.
REQ-018 pix_row  in  ROW_W  row within the glyph.
REQ-019 out_valid  out  1  result qualifier.
REQ-020 out_addr  out  ADDR_W  ROM address.
REQ-021 out_kind  out  1  0 = digit ROM, 1 = label ROM.
REQ-022 out_blank  out  1  draw background.

Function
REQ-023 Slot bank: SLOTS x 4-bit registers; when wr_en=1 and wr_slot<SLOTS, the slot SHALL be updated at the clock edge; writes with wr_slot>=SLOTS SHALL be ignored.
REQ-024 Pipeline: two stages; each output SHALL reflect the pix_* request sampled two edges earlier; out_valid SHALL equal pix_valid delayed by 2 cycles; there SHALL be no stalls.
REQ-025 Stage 1 SHALL read the slot value as it was before the edge on which the request is sampled; a write and a read to the same slot in the same cycle SHALL return the old value.
REQ-026 Pointer, digits 0-9: pointer = value*DIGIT_H, out_kind=0.
REQ-027 Pointer, labels: 10->0, 11->LABEL_H, 12->0, 13->0, 14->LABEL_H, out_kind=1.
REQ-028 out_addr SHALL equal pointer + pix_row, computed at ADDR_W bits without overflow. The design requires 10*DIGIT_H <= 2^ADDR_W; a violation SHALL cause an elaboration error.
REQ-029 out_blank=1 and out_addr=0 SHALL be produced when any of the following holds:
  - value=15;
  - pix_slot>=SLOTS;
  - pix_row>=DIGIT_H for digits, or pix_row>=LABEL_H for labels;
  - blink_phase=1 and blink_mask[pix_slot]=1.
REQ-030 Blink timer: the counter SHALL increment on frame_tick; on reaching BLINK_FRAMES-1 with frame_tick, it SHALL wrap to 0 and toggle blink_phase.
REQ-031 The blink_phase and blink_mask values used for a request SHALL be those sampled in stage 1 of that request.
REQ-032 When out_valid=0, out_addr, out_kind and out_blank SHALL be held at their previous values.

Reset
REQ-033 When reset=1 at an edge, the following SHALL result:
  - all slots = 15;
  - blink counter = 0, blink_phase = 0;
  - both pipeline valid bits = 0;
  - out_addr = 0, out_kind = 0, out_blank = 1, out_valid = 0.
REQ-034 Reset asserted mid-pipeline SHALL discard in-flight requests; no out_valid SHALL follow reset until two cycles after the first pix_valid.
REQ-035 reset SHALL take priority over a wr_en in the same cycle.

Structure
REQ-036 The shared package SHALL hold the glyph code constants (GLYPH_AM=10 through GLYPH_BLANK=15) and the default DIGIT_H, LABEL_H and BLINK_FRAMES values.
REQ-037 A single sub-module, glyph_pointer_lut, SHALL hold the combinational value->(pointer, kind, height) map; glyph_pointer_gen SHALL instantiate it in stage 2.

Verification
REQ-038 Scenario: write slot 2=7; request slot 2, row 5 -> two cycles later out_valid=1, out_addr=425, out_kind=0, out_blank=0.
REQ-039 Scenario: write slot 0=11; request row 3 -> out_addr=23, out_kind=1. Then request row 20 -> out_blank=1, out_addr=0.
REQ-040 Scenario: write slot 1=3 and request slot 1 in the same cycle, previous value 9, row 0 -> out_addr=540. Next request -> out_addr=180.
REQ-041 Scenario: blink_mask=6'b000100, slot 2=4; 30 frame_ticks -> slot 2 requests give out_blank=1 and slot 3 requests are unaffected. 30 more ticks -> slot 2 is visible again.
REQ-042 Scenario: pix_valid held at 1; assert reset for 1 cycle mid-stream -> out_valid=0 for exactly 2 cycles after reset is released, and all slots read blank.
REQ-043 Scenario: wr_slot=6 with SLOTS=6 -> no slot changes; request pix_slot=7 -> out_blank=1.
